// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: debug/ALU/load writers share one write port,
// with a registered output stage and a pending-write scoreboard for the decoder.
package regfile_write_arbiter_pkg;
    typedef enum logic [1:0] {REG_R0, REG_R1, REG_R2, REG_R3} register_sel_e;
    typedef enum logic {REG_NOP = 1'b0, REG_WRITE = 1'b1} registers_op_e;
endpackage

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH   = 8,
    parameter int DBG_STARVE_LIMIT = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  register_sel_e             alu_sel,
    input  logic [DATA_BUS_WIDTH-1:0] alu_data,
    output logic                      alu_ready,
    input  logic                      ld_valid,
    input  register_sel_e             ld_sel,
    input  logic [DATA_BUS_WIDTH-1:0] ld_data,
    output logic                      ld_ready,
    input  logic                      dbg_valid,
    input  register_sel_e             dbg_sel,
    input  logic [DATA_BUS_WIDTH-1:0] dbg_data,
    output logic                      dbg_ready,
    input  logic                      reserve_valid,
    input  register_sel_e             reserve_sel,
    output logic [3:0]                busy,
    output registers_op_e             rf_op,
    output register_sel_e             rf_sel,
    output logic [DATA_BUS_WIDTH-1:0] rf_data
);
    localparam logic [2:0] STARVE_LIMIT = 3'(DBG_STARVE_LIMIT);

    logic                      rr_ptr_q, rr_ptr_d;
    logic [2:0]                starve_q, starve_d;
    logic [3:0]                busy_q, busy_d;
    registers_op_e             rf_op_q, rf_op_d;
    register_sel_e             rf_sel_q, rf_sel_d;
    logic [DATA_BUS_WIDTH-1:0] rf_data_q, rf_data_d;

    logic normal_req, dbg_blocked;
    logic alu_grant, ld_grant, dbg_grant;

    // Grants depend only on valids, rr_ptr and the starvation counter.
    always_comb begin
        normal_req  = alu_valid | ld_valid;
        dbg_blocked = normal_req && (starve_q == STARVE_LIMIT);
        dbg_grant   = reset && dbg_valid && !dbg_blocked;
        alu_grant   = reset && !dbg_grant && alu_valid && (!ld_valid || !rr_ptr_q);
        ld_grant    = reset && !dbg_grant && ld_valid && (!alu_valid || rr_ptr_q);
    end

    assign alu_ready = alu_grant;
    assign ld_ready  = ld_grant;
    assign dbg_ready = dbg_grant;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        starve_d  = starve_q;
        busy_d    = busy_q;
        rf_op_d   = REG_NOP;
        rf_sel_d  = rf_sel_q;
        rf_data_d = rf_data_q;

        if (dbg_grant) begin
            rf_op_d   = REG_WRITE;
            rf_sel_d  = dbg_sel;
            rf_data_d = dbg_data;
        end else if (alu_grant) begin
            rf_op_d     = REG_WRITE;
            rf_sel_d    = alu_sel;
            rf_data_d   = alu_data;
            rr_ptr_d    = 1'b1;
            busy_d[alu_sel] = 1'b0;
        end else if (ld_grant) begin
            rf_op_d     = REG_WRITE;
            rf_sel_d    = ld_sel;
            rf_data_d   = ld_data;
            rr_ptr_d    = 1'b0;
            busy_d[ld_sel] = 1'b0;
        end

        if (alu_grant || ld_grant || !normal_req) begin
            starve_d = 3'd0;
        end else if (dbg_grant && starve_q != STARVE_LIMIT) begin
            starve_d = starve_q + 3'd1;
        end

        // Applied after the clear so a same-cycle reservation wins.
        if (reserve_valid) begin
            busy_d[reserve_sel] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q  <= 1'b0;
            starve_q  <= 3'd0;
            busy_q    <= 4'b0000;
            rf_op_q   <= REG_NOP;
            rf_sel_q  <= REG_R0;
            rf_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            rf_op_q   <= rf_op_d;
            rf_sel_q  <= rf_sel_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign busy    = busy_q;
    assign rf_op   = rf_op_q;
    assign rf_sel  = rf_sel_q;
    assign rf_data = rf_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level model of grants, output stage and scoreboard.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int W     = 8;
    localparam int LIMIT = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0, ld_valid = 1'b0, dbg_valid = 1'b0, reserve_valid = 1'b0;
    register_sel_e alu_sel = REG_R0, ld_sel = REG_R0, dbg_sel = REG_R0, reserve_sel = REG_R0;
    logic [W-1:0]  alu_data = '0, ld_data = '0, dbg_data = '0;
    logic          alu_ready, ld_ready, dbg_ready;
    logic [3:0]    busy;
    registers_op_e rf_op;
    register_sel_e rf_sel;
    logic [W-1:0]  rf_data;

    int n_pass  = 0;
    int n_total = 0;

    regfile_write_arbiter #(.DATA_BUS_WIDTH(W), .DBG_STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data), .ld_ready(ld_ready),
        .dbg_valid(dbg_valid), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .reserve_valid(reserve_valid), .reserve_sel(reserve_sel), .busy(busy),
        .rf_op(rf_op), .rf_sel(rf_sel), .rf_data(rf_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        alu_valid = 0; ld_valid = 0; dbg_valid = 0; reserve_valid = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    // Grant code from ready outputs: 0 none, 1 alu, 2 ld, 3 dbg, 7 illegal (not one-hot).
    function automatic int grant_code();
        case ({dbg_ready, ld_ready, alu_ready})
            3'b000:  return 0;
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 7;
        endcase
    endfunction

    task automatic test_reset();
        reset = 0;
        alu_valid = 1; ld_valid = 1; dbg_valid = 1;
        #1;
        n_total++;
        if (grant_code() !== 0) $display("FAIL reset_ready: got %0d want 0", grant_code());
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (rf_op !== REG_NOP || rf_sel !== REG_R0 || rf_data !== 8'h00 || busy !== 4'b0000)
            $display("FAIL reset_state: op=%0d sel=%0d data=%h busy=%b want 0/0/00/0000",
                     rf_op, rf_sel, rf_data, busy);
        else n_pass++;
        set_idle();
        reset = 1;
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_sel = REG_R2; alu_data = 8'h5A;
        #1;
        n_total++;
        if (grant_code() !== 1) $display("FAIL single_ready: got %0d want 1", grant_code());
        else n_pass++;
        tick();
        alu_valid = 0;
        n_total++;
        if (rf_op !== REG_WRITE || rf_sel !== REG_R2 || rf_data !== 8'h5A)
            $display("FAIL single_write: op=%0d sel=%0d data=%h want 1/2/5a", rf_op, rf_sel, rf_data);
        else n_pass++;
        tick();
        n_total++;
        if (rf_op !== REG_NOP || rf_sel !== REG_R2 || rf_data !== 8'h5A)
            $display("FAIL single_nop_hold: op=%0d sel=%0d data=%h want 0/2/5a", rf_op, rf_sel, rf_data);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_g[4] = '{1, 2, 1, 2};
        do_reset();
        alu_valid = 1; alu_sel = REG_R0; alu_data = 8'h11;
        ld_valid  = 1; ld_sel  = REG_R1; ld_data  = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (grant_code() !== exp_g[i]) $display("FAIL rr_grant[%0d]: got %0d want %0d", i, grant_code(), exp_g[i]);
            else n_pass++;
            tick();
            n_total++;
            if (rf_op !== REG_WRITE || int'(rf_sel) !== exp_g[i] - 1)
                $display("FAIL rr_sel[%0d]: op=%0d sel=%0d want 1/%0d", i, rf_op, rf_sel, exp_g[i] - 1);
            else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_dbg_starve();
        int exp_g[8] = '{3, 3, 3, 1, 3, 3, 3, 2};
        do_reset();
        dbg_valid = 1; dbg_sel = REG_R3; dbg_data = 8'h33;
        alu_valid = 1; alu_sel = REG_R0; alu_data = 8'h44;
        ld_valid  = 1; ld_sel  = REG_R1; ld_data  = 8'h55;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_total++;
            if (grant_code() !== exp_g[i]) $display("FAIL starve_grant[%0d]: got %0d want %0d", i, grant_code(), exp_g[i]);
            else n_pass++;
            tick();
        end
        set_idle();
    endtask

    task automatic test_scoreboard();
        do_reset();
        reserve_valid = 1; reserve_sel = REG_R1;
        tick();
        reserve_valid = 0;
        n_total++;
        if (busy !== 4'b0010) $display("FAIL sb_set: busy=%b want 0010", busy);
        else n_pass++;
        tick();
        ld_valid = 1; ld_sel = REG_R1; ld_data = 8'h77;
        n_total++;
        if (busy !== 4'b0010) $display("FAIL sb_hold: busy=%b want 0010", busy);
        else n_pass++;
        tick();
        ld_valid = 0;
        n_total++;
        if (busy !== 4'b0000) $display("FAIL sb_clear: busy=%b want 0000", busy);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        do_reset();
        reserve_valid = 1; reserve_sel = REG_R3;
        tick();
        alu_valid = 1; alu_sel = REG_R3; alu_data = 8'h99;
        tick();
        set_idle();
        n_total++;
        if (busy !== 4'b1000) $display("FAIL sb_set_wins: busy=%b want 1000", busy);
        else n_pass++;
        dbg_valid = 1; dbg_sel = REG_R3; dbg_data = 8'hAB;
        tick();
        dbg_valid = 0;
        n_total++;
        if (busy !== 4'b1000 || rf_op !== REG_WRITE || rf_sel !== REG_R3 || rf_data !== 8'hAB)
            $display("FAIL sb_dbg_keeps: busy=%b op=%0d sel=%0d data=%h want 1000/1/3/ab", busy, rf_op, rf_sel, rf_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1; alu_sel = REG_R1; alu_data = 8'h3C;
        reserve_valid = 1; reserve_sel = REG_R0;
        tick();
        reserve_valid = 0;
        ld_valid = 1; ld_sel = REG_R2; ld_data = 8'hC3;
        reset = 0;
        #1;
        n_total++;
        if (grant_code() !== 0) $display("FAIL mid_reset_ready: got %0d want 0", grant_code());
        else n_pass++;
        tick();
        n_total++;
        if (rf_op !== REG_NOP || busy !== 4'b0000)
            $display("FAIL mid_reset_state: op=%0d busy=%b want 0/0000", rf_op, busy);
        else n_pass++;
        reset = 1;
        #1;
        n_total++;
        if (grant_code() !== 1) $display("FAIL mid_reset_rr: got %0d want 1", grant_code());
        else n_pass++;
        tick();
        set_idle();
    endtask

    // Randomized traffic against a rule-level model.
    task automatic test_random();
        bit        v[3];
        int        s[3];
        int        d[3];
        bit        m_busy[4];
        int        m_favour_ld, m_dbg_run, exp_op, exp_sel, exp_data, g, busy_exp;
        bit        normal, res_v;
        int        res_s;
        do_reset();
        m_favour_ld = 0; m_dbg_run = 0; exp_op = 0; exp_sel = 0; exp_data = 0;
        for (int r = 0; r < 4; r++) m_busy[r] = 0;
        for (int w = 0; w < 3; w++) begin v[w] = 0; s[w] = 0; d[w] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int w = 0; w < 3; w++) begin
                if (!v[w]) begin
                    v[w] = ($urandom_range(0, 9) < 6);
                    s[w] = $urandom_range(0, 3);
                    d[w] = $urandom_range(0, 255);
                end
            end
            res_v = ($urandom_range(0, 3) == 0);
            res_s = $urandom_range(0, 3);
            alu_valid = v[0]; alu_sel = register_sel_e'(s[0]); alu_data = W'(d[0]);
            ld_valid  = v[1]; ld_sel  = register_sel_e'(s[1]); ld_data  = W'(d[1]);
            dbg_valid = v[2]; dbg_sel = register_sel_e'(s[2]); dbg_data = W'(d[2]);
            reserve_valid = res_v; reserve_sel = register_sel_e'(res_s);

            normal = v[0] || v[1];
            if (v[2] && !(normal && m_dbg_run == LIMIT)) g = 3;
            else if (v[0] && v[1]) g = m_favour_ld ? 2 : 1;
            else if (v[0]) g = 1;
            else if (v[1]) g = 2;
            else g = 0;

            #1;
            n_total++;
            if (grant_code() !== g) $display("FAIL rand_grant[%0d]: got %0d want %0d", cyc, grant_code(), g);
            else n_pass++;
            tick();

            if (g == 3 && normal) m_dbg_run = (m_dbg_run < LIMIT) ? m_dbg_run + 1 : LIMIT;
            else if (g == 1 || g == 2 || !normal) m_dbg_run = 0;
            if (g == 1) m_favour_ld = 1;
            if (g == 2) m_favour_ld = 0;
            if (g != 0) begin
                exp_op = 1; exp_sel = s[g-1]; exp_data = d[g-1];
                v[g-1] = 0;
            end else begin
                exp_op = 0;
            end
            if (g == 1 || g == 2) m_busy[s[g-1]] = 0;
            if (res_v) m_busy[res_s] = 1;
            busy_exp = 0;
            for (int r = 0; r < 4; r++) if (m_busy[r]) busy_exp += (1 << r);

            n_total++;
            if (int'(rf_op) !== exp_op || int'(rf_sel) !== exp_sel || int'(rf_data) !== exp_data || int'(busy) !== busy_exp)
                $display("FAIL rand_out[%0d]: op=%0d sel=%0d data=%h busy=%b want %0d/%0d/%h/%b",
                         cyc, rf_op, rf_sel, rf_data, busy, exp_op, exp_sel, exp_data, 4'(busy_exp));
            else n_pass++;
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_round_robin();
        test_dbg_starve();
        test_scoreboard();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
